// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state encodings and the address-writability rule for the register bank
package regfile_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DUMP  = 2'd2;

   // An address is writable (and readable as a real cell) when it exists and is not a hardwired-zero r0
   function automatic logic is_writable(input int unsigned addr, input int unsigned celdas, input logic zero_reg);
      return (addr < celdas) && !(zero_reg && addr == 0);
   endfunction

endpackage

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: soft-clear sequencer and handshaked dump stream controller
//   clk, rst_n            clock, asynchronous active-low reset
//   clear, dump_start     one-cycle requests (clear wins when both arrive)
//   dump_ready            consumer ready for the dump stream
//   clear_we, clear_addr  zero-write strobe and target for the storage array
//   idx                   current dump index for the dump read mux
//   dump_valid, dump_last dump stream qualifiers
//   busy                  registered "not idle"
module regfile_seq_ctrl
   import regfile_pkg::*;
#(
   parameter int REGS   = 5,
   parameter int CELDAS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            dump_start,
   input  logic            dump_ready,
   output logic            clear_we,
   output logic [REGS-1:0] clear_addr,
   output logic [REGS-1:0] idx,
   output logic            dump_valid,
   output logic            dump_last,
   output logic            busy
);

   // One extra bit so the counter never wraps when CELDAS == 2**REGS
   localparam logic [REGS:0] LAST = (REGS + 1)'(CELDAS - 1);

   logic [1:0]    state, state_n;
   logic [REGS:0] cnt, cnt_n;
   logic          go_clr, go_dmp, step, done;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         busy  <= state_n != ST_IDLE;
      end

   always_comb begin
      go_clr  = state == ST_IDLE && clear;
      go_dmp  = state == ST_IDLE && !clear && dump_start;
      step    = state == ST_CLEAR || (state == ST_DUMP && dump_ready);
      done    = step && cnt == LAST;
      state_n = go_clr ? ST_CLEAR : go_dmp ? ST_DUMP : done ? ST_IDLE : state;
      cnt_n   = (go_clr || go_dmp) ? '0 : step ? cnt + 1'b1 : cnt;
   end

   always_comb begin
      clear_we   = state == ST_CLEAR;
      dump_valid = state == ST_DUMP;
      dump_last  = dump_valid && cnt == LAST;
      clear_addr = cnt[REGS-1:0];
      idx        = cnt[REGS-1:0];
   end

endmodule

// File: rtl/regfile_multimode.sv
// regfile_multimode: 2R/1W register bank with same-cycle bypass, debug read, soft clear and dump stream
//   i_clk, i_reset_n                     clock, asynchronous active-low reset
//   i_RegWrite, i_RD, i_DatoEscritura    write port (commits on rising edge)
//   i_RS/o_RS, i_RT/o_RT                 combinational read ports with bypass
//   i_RegDebug/o_RegDebug                debug read port (no bypass)
//   i_clear, i_dump_start, i_dump_ready  sequencer requests and dump back-pressure
//   o_dump_valid/data/idx/last, o_busy   dump stream and sequencer status
module regfile_multimode
   import regfile_pkg::*;
#(
   parameter int NBITS    = 32,
   parameter int REGS     = 5,
   parameter int CELDAS   = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_RegWrite,
   input  logic [REGS-1:0]  i_RD,
   input  logic [NBITS-1:0] i_DatoEscritura,
   input  logic [REGS-1:0]  i_RS,
   input  logic [REGS-1:0]  i_RT,
   output logic [NBITS-1:0] o_RS,
   output logic [NBITS-1:0] o_RT,
   input  logic [REGS-1:0]  i_RegDebug,
   output logic [NBITS-1:0] o_RegDebug,
   input  logic             i_clear,
   input  logic             i_dump_start,
   input  logic             i_dump_ready,
   output logic             o_dump_valid,
   output logic [NBITS-1:0] o_dump_data,
   output logic [REGS-1:0]  o_dump_idx,
   output logic             o_dump_last,
   output logic             o_busy
);

   // Array spans the full address space; non-writable entries stay at their reset value of zero,
   // which makes reads of r0 (when hardwired) and of out-of-range addresses return 0 for free.
   logic [NBITS-1:0] mem [2**REGS];
   logic             clear_we, we;
   logic [REGS-1:0]  clear_addr, idx;

   regfile_seq_ctrl #(.REGS(REGS), .CELDAS(CELDAS)) u_seq (
      .clk        (i_clk),
      .rst_n      (i_reset_n),
      .clear      (i_clear),
      .dump_start (i_dump_start),
      .dump_ready (i_dump_ready),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .idx        (idx),
      .dump_valid (o_dump_valid),
      .dump_last  (o_dump_last),
      .busy       (o_busy)
   );

   // Pipeline writes are blocked during a clear; the pipeline is expected to stall on o_busy
   assign we = i_RegWrite && !clear_we && is_writable(32'(i_RD), CELDAS, ZERO_REG != 0);

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         for (int r = 0; r < 2**REGS; r++) mem[r] <= '0;
      end else begin
         for (int r = 0; r < 2**REGS; r++)
            if (is_writable(r, CELDAS, ZERO_REG != 0)) begin
               if (clear_we && clear_addr == REGS'(r)) mem[r] <= '0;
               else if (we && i_RD == REGS'(r)) mem[r] <= i_DatoEscritura;
            end
      end

   always_comb begin
      o_RS        = (BYPASS != 0 && we && i_RD == i_RS) ? i_DatoEscritura : mem[i_RS];
      o_RT        = (BYPASS != 0 && we && i_RD == i_RT) ? i_DatoEscritura : mem[i_RT];
      o_RegDebug  = mem[i_RegDebug];
      o_dump_data = mem[idx];
      o_dump_idx  = idx;
   end

endmodule

// File: tb/tb_regfile_multimode.sv
// tb_regfile_multimode: scoreboard bench for regfile_multimode
module tb_regfile_multimode;

   localparam int NBITS = 32;
   localparam int REGS  = 5;

   logic             i_clk = 1'b0;
   logic             i_reset_n = 1'b0;
   logic             i_RegWrite = 1'b0;
   logic [REGS-1:0]  i_RD = '0;
   logic [NBITS-1:0] i_DatoEscritura = '0;
   logic [REGS-1:0]  i_RS = '0;
   logic [REGS-1:0]  i_RT = '0;
   logic [NBITS-1:0] o_RS, o_RT, o_RegDebug, o_dump_data;
   logic [REGS-1:0]  i_RegDebug = '0;
   logic             i_clear = 1'b0;
   logic             i_dump_start = 1'b0;
   logic             i_dump_ready = 1'b0;
   logic             o_dump_valid, o_dump_last, o_busy;
   logic [REGS-1:0]  o_dump_idx;

   int n_cmp = 0;
   int n_err = 0;
   logic [NBITS+REGS:0] dq [$];

   regfile_multimode dut (
      .i_clk           (i_clk),
      .i_reset_n       (i_reset_n),
      .i_RegWrite      (i_RegWrite),
      .i_RD            (i_RD),
      .i_DatoEscritura (i_DatoEscritura),
      .i_RS            (i_RS),
      .i_RT            (i_RT),
      .o_RS            (o_RS),
      .o_RT            (o_RT),
      .i_RegDebug      (i_RegDebug),
      .o_RegDebug      (o_RegDebug),
      .i_clear         (i_clear),
      .i_dump_start    (i_dump_start),
      .i_dump_ready    (i_dump_ready),
      .o_dump_valid    (o_dump_valid),
      .o_dump_data     (o_dump_data),
      .o_dump_idx      (o_dump_idx),
      .o_dump_last     (o_dump_last),
      .o_busy          (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] off, input int mul);
      for (int i = 1; i < 32; i++) begin
         i_RegWrite = 1'b1;
         i_RD = REGS'(i);
         i_DatoEscritura = off + 32'(i * mul);
         tick;
      end
      i_RegWrite = 1'b0;
   endtask

   task automatic push_dump(input logic [NBITS-1:0] r4);
      for (int i = 0; i < 32; i++)
         dq.push_back({i == 31, REGS'(i), (i == 0) ? 32'h0 : (i == 4) ? r4 : 32'h100 + 32'(i)});
   endtask

   // Scoreboard consumer: every accepted dump word must match the next expected entry
   always @(negedge i_clk)
      if (i_reset_n && o_dump_valid && i_dump_ready) begin
         if (dq.size() == 0) chk("dump_extra", 64'(o_dump_valid), 64'd0);
         else chk("dump_word", 64'({o_dump_last, o_dump_idx, o_dump_data}), 64'(dq.pop_front()));
      end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  n;
      logic saw;
      i_RS = 5;
      #3;
      chk("rst_busy", 64'(o_busy), 0);
      chk("rst_valid", 64'(o_dump_valid), 0);
      chk("rst_last", 64'(o_dump_last), 0);
      chk("rst_idx", 64'(o_dump_idx), 0);
      chk("rst_rs", 64'(o_RS), 0);
      tick;
      i_reset_n = 1'b1;
      tick;

      i_RegWrite = 1'b1; i_RD = 5; i_DatoEscritura = 32'hDEADBEEF; i_RS = 5;
      #1 chk("bypass_rs", 64'(o_RS), 64'hDEADBEEF);
      chk("pre_commit_dbg", 64'(o_RegDebug), 0);
      tick;
      i_RegWrite = 1'b0; i_RegDebug = 5; i_RT = 5;
      #1 chk("commit_dbg", 64'(o_RegDebug), 64'hDEADBEEF);
      chk("commit_rt", 64'(o_RT), 64'hDEADBEEF);

      i_RegWrite = 1'b1; i_RD = 0; i_DatoEscritura = 32'h1234; i_RS = 0;
      #1 chk("r0_bypass", 64'(o_RS), 0);
      tick;
      i_RegWrite = 1'b0;
      #1 chk("r0_stored", 64'(o_RS), 0);

      fill(0, 3);
      i_RT = 30;
      #1 chk("fill_r30", 64'(o_RT), 90);
      i_clear = 1'b1;
      tick;
      i_clear = 1'b0;
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         if (n == 20) begin
            i_RegWrite = 1'b1; i_RD = 7; i_DatoEscritura = 32'h77; i_RS = 7;
            #1 chk("clr_nobypass", 64'(o_RS), 0);
         end
         tick;
         i_RegWrite = 1'b0;
      end
      chk("clr_busy_cycles", 64'(n), 32);
      for (int i = 0; i < 32; i++) begin
         i_RegDebug = REGS'(i);
         #1 chk("clr_zero", 64'(o_RegDebug), 0);
      end

      fill(32'h100, 1);
      i_dump_ready = 1'b1;
      push_dump(32'h104);
      i_dump_start = 1'b1;
      tick;
      i_dump_start = 1'b0;
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         tick;
      end
      chk("dump_busy_cycles", 64'(n), 32);
      chk("dump_left", 64'(dq.size()), 0);
      chk("dump_valid_drop", 64'(o_dump_valid), 0);

      push_dump(32'hAA);
      i_dump_start = 1'b1;
      tick;
      i_dump_start = 1'b0;
      n = 0;
      while (o_dump_idx != 4 && n < 100) begin
         n++;
         tick;
      end
      chk("stall_reach4", 64'(o_dump_idx), 4);
      i_dump_ready = 1'b0;
      i_RegWrite = 1'b1; i_RD = 4; i_DatoEscritura = 32'hAA;
      #1 chk("stall_idx0", 64'(o_dump_idx), 4);
      chk("stall_data0", 64'(o_dump_data), 64'h104);
      tick;
      i_RegWrite = 1'b0;
      chk("stall_idx1", 64'(o_dump_idx), 4);
      chk("stall_data1", 64'(o_dump_data), 64'hAA);
      tick;
      chk("stall_idx2", 64'(o_dump_idx), 4);
      chk("stall_data2", 64'(o_dump_data), 64'hAA);
      tick;
      i_dump_ready = 1'b1;
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         tick;
      end
      chk("stall_left", 64'(dq.size()), 0);

      i_clear = 1'b1; i_dump_start = 1'b1;
      tick;
      i_clear = 1'b0; i_dump_start = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         saw |= o_dump_valid;
         tick;
      end
      chk("cd_busy", 64'(o_busy), 1);
      chk("cd_no_dump", 64'(saw | o_dump_valid), 0);
      i_RegDebug = 20;
      #1 chk("cd_r20_live", 64'(o_RegDebug), 64'h114);
      i_reset_n = 1'b0;
      #1 chk("arst_busy", 64'(o_busy), 0);
      for (int i = 0; i < 32; i++) begin
         i_RegDebug = REGS'(i);
         #1 chk("arst_zero", 64'(o_RegDebug), 0);
      end
      tick;
      i_reset_n = 1'b1;
      tick;
      tick;
      chk("post_busy", 64'(o_busy), 0);
      chk("post_valid", 64'(o_dump_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
